// File: rtl/ss_display_pkg.sv
// Shared seven-segment types and the hex-to-segment table (active-low {g,f,e,d,c,b,a}).
// Pure constants; no timing or flow-control behaviour of its own.
package ss_display_pkg;

  typedef logic [3:0] hexdig_t;
  typedef logic [6:0] segs_t;

  localparam segs_t SEG_BLANK = 7'h7F;

  localparam segs_t SEG_DECODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/ss_hexdec.sv
// Hex digit to active-low segment pattern.
// Purely combinational, zero latency, no backpressure.
module ss_hexdec
  import ss_display_pkg::*;
(
  input  hexdig_t i_dig,
  output segs_t   o_seg
);

  assign o_seg = SEG_DECODE[i_dig];

endmodule

// File: rtl/ss_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with tear-free frame-boundary updates.
// Outputs registered (1 cycle after sel); ready drops while an update waits for the frame boundary.
module ss_scan_ctrl
  import ss_display_pkg::*;
#(
  parameter int NDIGITS   = 8,
  parameter int CLK_DIV   = 100000,
  parameter int BLINK_DIV = 64
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   load,
  output logic                   ready,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blink_en,
  input  logic                   blank_lz,
  output logic [6:0]             seg,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int SW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SEL_LAST   = SW'(NDIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [TW-1:0]          r_tick;
  logic [SW-1:0]          r_sel;
  logic [FW-1:0]          r_frame;
  logic                   r_phase;
  logic                   r_pend;
  logic [4*NDIGITS-1:0]   r_pend_val;
  logic [NDIGITS-1:0]     r_pend_dp;
  logic [NDIGITS-1:0]     r_pend_blk;
  logic [4*NDIGITS-1:0]   r_disp_val;
  logic [NDIGITS-1:0]     r_disp_dp;
  logic [NDIGITS-1:0]     r_disp_blk;
  logic [NDIGITS-1:0]     r_an;
  segs_t                  r_seg;
  logic                   r_dp_n;

  logic                   w_slot;
  logic                   w_bound;
  hexdig_t                w_dig;
  segs_t                  w_dig_seg;
  logic [NDIGITS-1:0]     w_lz;
  logic                   w_blank;
  logic [NDIGITS-1:0]     w_an_sel;

  assign w_slot  = (r_tick == TICK_LAST);
  assign w_bound = w_slot && (r_sel == SEL_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tick  <= '0;
      r_sel   <= '0;
      r_frame <= '0;
      r_phase <= 1'b0;
    end else begin
      r_tick <= w_slot ? '0 : r_tick + 1'b1;
      if (w_slot)
        r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
      if (w_bound) begin
        if (r_frame == FRAME_LAST) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  // Capture and commit are exclusive: a capture on a boundary cycle sees r_pend=0,
  // so it waits for the following boundary.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_blk <= '0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_disp_blk <= '0;
    end else if (!r_pend) begin
      if (load) begin
        r_pend     <= 1'b1;
        r_pend_val <= value;
        r_pend_dp  <= dp;
        r_pend_blk <= blink_en;
      end
    end else if (w_bound) begin
      r_pend     <= 1'b0;
      r_disp_val <= r_pend_val;
      r_disp_dp  <= r_pend_dp;
      r_disp_blk <= r_pend_blk;
    end
  end

  assign ready = ~r_pend;

  // Digit i is a leading zero when the value shifted down to it is entirely zero.
  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_lz
    assign w_lz[gi] = ((r_disp_val >> (4 * gi)) == '0);
  end

  assign w_dig    = r_disp_val[4*r_sel +: 4];
  assign w_an_sel = ~(NDIGITS'(1) << r_sel);
  assign w_blank  = (blank_lz && (r_sel != '0) && w_lz[r_sel]) ||
                    (r_phase && r_disp_blk[r_sel]);

  ss_hexdec u_hexdec (
    .i_dig (w_dig),
    .o_seg (w_dig_seg)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_an   <= '1;
      r_seg  <= SEG_BLANK;
      r_dp_n <= 1'b1;
    end else if (w_blank) begin
      r_an   <= '1;
      r_seg  <= SEG_BLANK;
      r_dp_n <= 1'b1;
    end else begin
      r_an   <= w_an_sel;
      r_seg  <= w_dig_seg;
      r_dp_n <= ~r_disp_dp[r_sel];
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp_n = r_dp_n;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Directed bench for ss_scan_ctrl with NDIGITS=4, CLK_DIV=4, BLINK_DIV=2.
// Edge k counts posedges since reset release; outputs at edge k show digit ((k-1)/4)%4.
module tb_ss_scan_ctrl;

  logic        CLK;
  logic        nRST;
  logic        load;
  logic        ready;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blink_en;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ss_scan_ctrl #(
    .NDIGITS   (4),
    .CLK_DIV   (4),
    .BLINK_DIV (2)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (load),
    .ready    (ready),
    .value    (value),
    .dp       (dp),
    .blink_en (blink_en),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp_n     (dp_n),
    .an       (an)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                         input logic dpn_e);
    chk(tag, {4'h0, an, seg, dp_n}, {4'h0, an_e, seg_e, dpn_e});
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    chk(tag, 16'(ready), 16'(exp));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value    = v;
    dp       = d;
    blink_en = b;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  initial begin
    nRST     = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp       = '0;
    blink_en = '0;
    blank_lz = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk_out("reset_outputs", 4'hF, 7'h7F, 1'b1);
    chk_rdy("reset_ready", 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    chk_out("reset_held_outputs", 4'hF, 7'h7F, 1'b1);
    nRST = 1'b1;
    cyc  = 0;

    // Idle display of the zeroed register.
    run_to(1);
    chk_out("idle_d0_first", 4'hE, 7'h40, 1'b1);
    run_to(17);
    chk_out("idle_d0_after_boundary", 4'hE, 7'h40, 1'b1);

    // Load 12AF with dp on digit 2; a second load while pending is ignored.
    do_load(16'h12AF, 4'b0100, 4'b0000);
    chk_rdy("ready_low_after_load", 1'b0);
    run_to(20);
    do_load(16'h5555, 4'b0000, 4'b0000);
    chk_rdy("ready_low_ignored_load", 1'b0);
    run_to(31);
    chk_rdy("ready_low_before_commit", 1'b0);
    run_to(32);
    chk_rdy("ready_high_after_commit", 1'b1);
    run_to(33);
    chk_out("v12AF_d0", 4'hE, 7'h0E, 1'b1);
    run_to(37);
    chk_out("v12AF_d1", 4'hD, 7'h08, 1'b1);
    run_to(41);
    chk_out("v12AF_d2_dp", 4'hB, 7'h24, 1'b0);
    run_to(45);
    chk_out("v12AF_d3", 4'h7, 7'h79, 1'b1);
    run_to(49);
    chk_out("v12AF_kept_d0", 4'hE, 7'h0E, 1'b1);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0007, 4'b0000, 4'b0000);
    run_to(65);
    chk_out("lz7_d0", 4'hE, 7'h78, 1'b1);
    run_to(69);
    chk_out("lz7_d1_blank", 4'hF, 7'h7F, 1'b1);
    run_to(73);
    chk_out("lz7_d2_blank", 4'hF, 7'h7F, 1'b1);
    run_to(77);
    chk_out("lz7_d3_blank", 4'hF, 7'h7F, 1'b1);
    do_load(16'h0000, 4'b0011, 4'b0000);
    run_to(81);
    chk_out("lz0_d0_dp", 4'hE, 7'h40, 1'b0);
    run_to(85);
    chk_out("lz0_d1_blank_dp", 4'hF, 7'h7F, 1'b1);

    // Blink digit 0; phase is 1 for edges 97..128 and 161..192.
    blank_lz = 1'b0;
    do_load(16'h4321, 4'b0000, 4'b0001);
    run_to(97);
    chk_out("blink_on_d0", 4'hF, 7'h7F, 1'b1);
    run_to(101);
    chk_out("blink_on_d1", 4'hD, 7'h24, 1'b1);
    run_to(113);
    chk_out("blink_on2_d0", 4'hF, 7'h7F, 1'b1);
    run_to(117);
    chk_out("blink_on2_d1", 4'hD, 7'h24, 1'b1);
    run_to(129);
    chk_out("blink_off_d0", 4'hE, 7'h79, 1'b1);
    run_to(133);
    chk_out("blink_off_d1", 4'hD, 7'h24, 1'b1);
    run_to(145);
    chk_out("blink_off2_d0", 4'hE, 7'h79, 1'b1);
    run_to(161);
    chk_out("blink_on3_d0", 4'hF, 7'h7F, 1'b1);
    run_to(165);
    chk_out("blink_on3_d1", 4'hD, 7'h24, 1'b1);

    // Load captured on the boundary edge 176 commits at 192.
    run_to(175);
    do_load(16'h89C0, 4'b0000, 4'b0000);
    chk_rdy("bnd_ready_low", 1'b0);
    run_to(181);
    chk_out("bnd_old_d1", 4'hD, 7'h24, 1'b1);
    run_to(191);
    chk_rdy("bnd_ready_still_low", 1'b0);
    run_to(192);
    chk_rdy("bnd_ready_high", 1'b1);
    run_to(193);
    chk_out("bnd_new_d0", 4'hE, 7'h40, 1'b1);
    run_to(197);
    chk_out("bnd_new_d1", 4'hD, 7'h27, 1'b1);

    // Reset while a load is pending drops it.
    do_load(16'hFFFF, 4'b1111, 4'b1111);
    chk_rdy("pend_ready_low", 1'b0);
    run_to(200);
    nRST = 1'b0;
    #2;
    chk_rdy("rst_mid_ready", 1'b1);
    chk_out("rst_mid_outputs", 4'hF, 7'h7F, 1'b1);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cyc  = 0;
    run_to(1);
    chk_out("post_rst_d0", 4'hE, 7'h40, 1'b1);
    run_to(5);
    chk_out("post_rst_d1", 4'hD, 7'h40, 1'b1);
    run_to(16);
    chk_rdy("post_rst_ready", 1'b1);
    run_to(17);
    chk_out("post_rst_no_commit_d0", 4'hE, 7'h40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ss_scan_ctrl.md
# ss_scan_ctrl

Parametrised, time-multiplexed seven-segment scan controller. It displays NDIGITS hex digits from a value that a CPU-side bus master loads through a ready/load handshake. New values commit only at frame boundaries, so the display never tears. Per-digit decimal points, leading-zero blanking and per-digit blinking are supported. It sits between the system bus/debug logic and the board's seven-segment pins, and replaces the fixed-pattern display path.

## Interface
- NDIGITS, 8: digit count, 1..16; digit NDIGITS-1 is most significant.
- CLK_DIV, 100000: CLK cycles per digit slot, >= 2.
- BLINK_DIV, 64: scan frames per blink half-period, >= 1.

- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- load  in  1  request to capture value/dp/blink_en.
- ready  out  1  high when no update is pending; load is accepted only when ready=1.
- value  in  4*NDIGITS  hex digits; digit i is value[4i+3:4i].
- dp  in  NDIGITS  decimal-point enable per digit.
- blink_en  in  NDIGITS  per-digit blink enable.
- blank_lz  in  1  leading-zero blanking (live input, not latched).
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- an  out  NDIGITS  active-low anodes, one-hot-low.

## Operation
- Slot counter `tick` runs 0..CLK_DIV-1 and wraps. The slot strobe fires when tick==CLK_DIV-1.
- `sel` (width clog2(NDIGITS), min 1) advances on each slot strobe, modulo NDIGITS.
- Frame boundary = slot strobe while sel==NDIGITS-1.
- Handshake and register update:
  - load&&ready captures value/dp/blink_en into a pending register and sets pending; ready = !pending.
  - At the first frame boundary strictly after the capture cycle, pending is copied into the display register and pending clears.
  - load while ready=0 is ignored; the earlier pending value is kept.
- Blink:
  - The frame counter counts 0..BLINK_DIV-1; on its wrap, `phase` toggles.
  - When phase=1, digits with blink_en=1 are blanked.
- Leading-zero blanking:
  - With blank_lz=1, digit i is blanked if every digit j>=i is 0 and i!=0.
  - Digit 0 is always shown. Its dp still shows if its dp bit is set.
- Digit output for the selected digit s:
  - Not blanked: an[s]=0, seg=decode(digit s), dp_n=!dp[s].
  - Blanked: an all 1, seg=7'h7F, dp_n=1.
- Decode (hex to active-low segments): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=27, d=21, E=06, F=0E.

## Timing
- Reset (async, nRST=0) sets:
  - tick=0, sel=0, phase=0, frame count=0.
  - Display and pending registers = 0; pending=0.
  - an=all 1, seg=7'h7F, dp_n=1, ready=1.
- Outputs are registered: an/seg/dp_n reflect the sel value of the previous cycle (1-cycle latency after a sel change).
- ready falls the cycle after an accepted load. It rises the cycle after the commit boundary.
- A load accepted on the same cycle as a boundary commits at the next boundary, one frame later.
- Worst-case load-to-display latency: NDIGITS*CLK_DIV + 2 cycles.
- Reset mid-frame or mid-pending discards the pending value. The first scan after reset begins at digit 0.

## Structure
- Shared package `ss_display_pkg`:
  - `hexdig_t` (logic [3:0]);
  - `segs_t` (logic [6:0]);
  - constant `SEG_BLANK = 7'h7F`;
  - the 16-entry decode constant.
- One sub-module: `ss_hexdec` (combinational hex to segments, using the package constant).
- Counters, handshake and blanking logic live in the top module.

## Test plan
Bench parameters: NDIGITS=4, CLK_DIV=4, BLINK_DIV=2.
1. Reset then idle:
   - Check: an=4'hF, seg=7F, dp_n=1 and ready=1 immediately.
   - Check: after the first boundary, digit 0 shows seg=40.
2. load value=16'h12AF, dp=4'b0100:
   - Check: ready=0 the next cycle.
   - Check: after the boundary, scan gives an=E/seg=0E, D/08, B/24 with dp_n=0, 7/79.
   - Check: ready=1 one cycle after the commit.
3. Second load while ready=0 (value=16'h5555):
   - Check: it is ignored; the display stays 12AF.
4. blank_lz=1, value=16'h0007:
   - Check: digits 3..1 show an=F/seg=7F.
   - Check: digit 0 shows seg=78.
   - Check: value=0 shows only digit 0 = 40.
5. blink_en=4'b0001:
   - Check: digit 0 is blanked during alternate 2-frame periods.
   - Check: the other digits are steady.
6. Edge cases:
   - load on the boundary cycle: commits one frame later.
   - nRST pulse mid-pending: pending is dropped, ready=1, display = 0000.
